// File: rtl/dlsc_dma_pkg.sv
// Shared DMA helpers: lane count, FSM encoding, and byte-strobe utilities
// used by the realignment datapath.
package dlsc_dma_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } packer_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] s);
        return 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
    endfunction

    function automatic logic strb_contig(input logic [3:0] s);
        case (s)
            4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
            4'b0010, 4'b0110, 4'b1110,
            4'b0100, 4'b1100,
            4'b1000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [1:0] hi);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= int'(lo) && i <= int'(hi)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dlsc_byte_rotator.sv
// Builds the 7-byte window (residual bytes, then input bytes from its first
// set lane) and rotates it so window byte 0 lands on destination lane p.
module dlsc_byte_rotator
    import dlsc_dma_pkg::*;
(
    input  logic [23:0] res,
    input  logic [1:0]  res_cnt,
    input  logic [31:0] data,
    input  logic [1:0]  first,
    input  logic [1:0]  p,
    output logic [55:0] win,
    output logic [31:0] lanes
);

    logic [31:0] in_sh;
    logic [23:0] res_m;

    always_comb begin
        in_sh = data >> {first, 3'b000};
        res_m = res & ~(24'hFFFFFF << {res_cnt, 3'b000});
        win   = {32'h0, res_m} | ({24'h0, in_sh} << {res_cnt, 3'b000});
        lanes = 32'(win << {p, 3'b000});
    end

endmodule

// File: rtl/dlsc_axi_byte_packer.sv
// Re-packs a contiguous byte stream of 32-bit words onto a new destination
// byte offset; one registered output stage, input stalls on output backpressure.
module dlsc_axi_byte_packer
    import dlsc_dma_pkg::*;
#(
    parameter bit STRB_CHECK = 1'b1,
    parameter bit WARNINGS   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cmd_ready,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_offset,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_strb,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        out_last,
    output logic [31:0] out_data,
    output logic [3:0]  out_strb,
    output logic        cmd_done,
    output logic        strb_error
);

    packer_state_t state, state_nxt;

    logic [1:0]  p;
    logic [1:0]  c;
    logic [23:0] res;
    logic [1:0]  first;
    logic [2:0]  n;
    logic [3:0]  t;
    logic        t_ge4, t_gt4;
    logic        out_free, in_acc, load_run, load_flush;
    logic [2:0]  shift;
    logic [55:0] win;
    logic [31:0] lanes;
    logic [23:0] res_n;

    always_comb begin
        casez (in_strb)
            4'b???1: first = 2'd0;
            4'b??10: first = 2'd1;
            4'b?100: first = 2'd2;
            default: first = 2'd3;
        endcase
    end

    assign n          = popcount4(in_strb);
    assign t          = {2'b00, p} + {2'b00, c} + {1'b0, n};
    assign t_ge4      = (t >= 4'd4);
    assign t_gt4      = (t >  4'd4);
    assign out_free   = !out_valid || out_ready;
    assign in_acc     = in_valid && in_ready;
    assign load_run   = in_acc && (t_ge4 || in_last);
    assign load_flush = (state == ST_FLUSH) && out_free;
    // Bytes consumed into the output word are skipped when keeping the residual.
    assign shift      = t_ge4 ? (3'd4 - {1'b0, p}) : 3'd0;
    assign res_n      = 24'(win >> {shift, 3'b000});

    dlsc_byte_rotator u_rot (
        .res     (res),
        .res_cnt (c),
        .data    (in_data),
        .first   (first),
        .p       (p),
        .win     (win),
        .lanes   (lanes)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_nxt = ST_RUN;
            ST_RUN:   if (in_acc && in_last) state_nxt = t_gt4 ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: if (out_free) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        in_ready  = (state == ST_RUN) && out_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= 2'd0;
            c   <= 2'd0;
            res <= 24'h0;
        end else if (cmd_ready && cmd_valid) begin
            p <= cmd_offset;
            c <= 2'd0;
        end else if (in_acc) begin
            res <= res_n;
            if (t_ge4) begin
                p <= 2'd0;
                c <= 2'(t - 4'd4);
            end else begin
                c <= 2'(t - {2'b00, p});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_strb  <= 4'h0;
            out_data  <= 32'h0;
            cmd_done  <= 1'b0;
        end else begin
            cmd_done <= out_valid && out_ready && out_last;
            if (load_run) begin
                out_valid <= 1'b1;
                out_data  <= lanes;
                out_last  <= in_last && !t_gt4;
                if (t_ge4)              out_strb <= lane_mask(p, 2'd3);
                else if (t[1:0] == p)   out_strb <= 4'h0;
                else                    out_strb <= lane_mask(p, 2'(t - 4'd1));
            end else if (load_flush) begin
                out_valid <= 1'b1;
                out_data  <= {8'h00, res};
                out_strb  <= lane_mask(2'd0, c - 2'd1);
                out_last  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strb_error <= 1'b0;
        end else if (STRB_CHECK && in_acc && !strb_contig(in_strb)) begin
            strb_error <= 1'b1;
        end
    end

    if (WARNINGS) begin : g_warn
        logic stalled;
        always_ff @(posedge clk) begin
            if (rst) begin
                stalled <= 1'b0;
            end else begin
                stalled <= (state == ST_RUN) && in_valid && !out_free;
                if ((state == ST_RUN) && in_valid && !out_free && !stalled) begin
                    $warning("dlsc_axi_byte_packer: output backpressure is stalling input");
                end
            end
        end
    end

endmodule

// File: tb/tb_dlsc_axi_byte_packer.sv
// Directed bench for the byte packer: hand-computed output words per scenario.
module tb_dlsc_axi_byte_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_ready, cmd_valid = 1'b0;
    logic [1:0]  cmd_offset = 2'd0;
    logic        in_ready, in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  in_strb = 4'h0;
    logic        out_ready = 1'b1;
    logic        out_valid, out_last;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        cmd_done, strb_error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] q_dat[$];
    logic [3:0]  q_strb[$];
    logic        q_last[$];
    int          q_cyc[$];
    int          done_q[$];

    dlsc_axi_byte_packer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_offset (cmd_offset),
        .in_ready   (in_ready),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_data    (in_data),
        .in_strb    (in_strb),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_data   (out_data),
        .out_strb   (out_strb),
        .cmd_done   (cmd_done),
        .strb_error (strb_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_dat.push_back(out_data);
            q_strb.push_back(out_strb);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
        if (cmd_done) done_q.push_back(cyc);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic clear_q();
        q_dat.delete(); q_strb.delete(); q_last.delete(); q_cyc.delete(); done_q.delete();
    endtask

    task automatic send_cmd(input logic [1:0] off);
        cmd_valid = 1'b1;
        cmd_offset = off;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        in_valid = 1'b1; in_data = d; in_strb = s; in_last = l;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        for (int k = 0; k < 100 && q_dat.size() < n; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_last !== 1'b0)   begin fails++; $display("FAIL reset_out_last got %b want 0", out_last); end
        tests++; if (out_strb !== 4'h0)   begin fails++; $display("FAIL reset_out_strb got %b want 0000", out_strb); end
        tests++; if (cmd_done !== 1'b0)   begin fails++; $display("FAIL reset_cmd_done got %b want 0", cmd_done); end
        tests++; if (strb_error !== 1'b0) begin fails++; $display("FAIL reset_strb_error got %b want 0", strb_error); end
        tests++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_aligned(input string tag);
        logic [31:0] ed [2];
        logic [3:0]  es [2];
        logic        el [2];
        ed = '{32'h03020100, 32'h07060504};
        es = '{4'hF, 4'hF};
        el = '{1'b0, 1'b1};
        clear_q();
        send_cmd(2'd0);
        send_word(32'h03020100, 4'hF, 1'b0);
        send_word(32'h07060504, 4'hF, 1'b1);
        wait_outs(2);
        tests++; if (q_dat.size() != 2) begin fails++; $display("FAIL %s_count got %0d want 2", tag, q_dat.size()); end
        for (int i = 0; i < 2 && i < q_dat.size(); i++) begin
            tests++;
            if ({q_last[i], q_strb[i], q_dat[i] & bmask(es[i])} !== {el[i], es[i], ed[i] & bmask(es[i])}) begin
                fails++;
                $display("FAIL %s_word%0d got last=%b strb=%b data=%h want last=%b strb=%b data=%h",
                         tag, i, q_last[i], q_strb[i], q_dat[i], el[i], es[i], ed[i]);
            end
        end
        tests++;
        if (done_q.size() != 1 || q_cyc.size() < 2 || done_q[0] != q_cyc[1] + 1) begin
            fails++;
            $display("FAIL %s_cmd_done got %0d pulses (first at cycle %0d) want 1 pulse at handshake+1 (%0d)",
                     tag, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1,
                     (q_cyc.size() > 1) ? q_cyc[1] + 1 : -1);
        end
    endtask

    task automatic test_unaligned_src();
        clear_q();
        send_cmd(2'd0);
        send_word(32'h03020100, 4'b1100, 1'b0);
        send_word(32'h07060504, 4'b0011, 1'b1);
        wait_outs(1);
        tests++; if (q_dat.size() != 1) begin fails++; $display("FAIL unaligned_count got %0d want 1", q_dat.size()); end
        if (q_dat.size() > 0) begin
            tests++;
            if ({q_last[0], q_strb[0], q_dat[0]} !== {1'b1, 4'hF, 32'h05040302}) begin
                fails++;
                $display("FAIL unaligned_word got last=%b strb=%b data=%h want last=1 strb=1111 data=05040302",
                         q_last[0], q_strb[0], q_dat[0]);
            end
        end
    endtask

    task automatic test_offset3();
        logic [31:0] ed [2];
        logic [3:0]  es [2];
        logic        el [2];
        ed = '{32'h00000000, 32'h04030201};
        es = '{4'b1000, 4'hF};
        el = '{1'b0, 1'b1};
        clear_q();
        send_cmd(2'd3);
        send_word(32'h03020100, 4'hF, 1'b0);
        send_word(32'h07060504, 4'b0001, 1'b1);
        wait_outs(2);
        tests++; if (q_dat.size() != 2) begin fails++; $display("FAIL offset3_count got %0d want 2", q_dat.size()); end
        for (int i = 0; i < 2 && i < q_dat.size(); i++) begin
            tests++;
            if ({q_last[i], q_strb[i], q_dat[i] & bmask(es[i])} !== {el[i], es[i], ed[i] & bmask(es[i])}) begin
                fails++;
                $display("FAIL offset3_word%0d got last=%b strb=%b data=%h want last=%b strb=%b data=%h",
                         i, q_last[i], q_strb[i], q_dat[i], el[i], es[i], ed[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] ed [3];
        logic [3:0]  es [3];
        logic        el [3];
        ed = '{32'h01000000, 32'h05040302, 32'h00000706};
        es = '{4'b1100, 4'hF, 4'b0011};
        el = '{1'b0, 1'b0, 1'b1};
        clear_q();
        send_cmd(2'd2);
        send_word(32'h03020100, 4'hF, 1'b0);
        send_word(32'h07060504, 4'hF, 1'b1);
        wait_outs(3);
        tests++; if (q_dat.size() != 3) begin fails++; $display("FAIL flush_count got %0d want 3", q_dat.size()); end
        for (int i = 0; i < 3 && i < q_dat.size(); i++) begin
            tests++;
            if ({q_last[i], q_strb[i], q_dat[i] & bmask(es[i])} !== {el[i], es[i], ed[i] & bmask(es[i])}) begin
                fails++;
                $display("FAIL flush_word%0d got last=%b strb=%b data=%h want last=%b strb=%b data=%h",
                         i, q_last[i], q_strb[i], q_dat[i], el[i], es[i], ed[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed [5];
        logic [3:0]  es [5];
        logic        el [5];
        logic [31:0] d0;
        logic [3:0]  s0;
        ed = '{32'h02010000, 32'h06050403, 32'h0A090807, 32'h0E0D0C0B, 32'h0000000F};
        es = '{4'b1110, 4'hF, 4'hF, 4'hF, 4'b0001};
        el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_q();
        fork
            begin
                send_cmd(2'd1);
                send_word(32'h03020100, 4'hF, 1'b0);
                send_word(32'h07060504, 4'hF, 1'b0);
                send_word(32'h0B0A0908, 4'hF, 1'b0);
                send_word(32'h0F0E0D0C, 4'hF, 1'b1);
            end
            begin
                for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                d0 = out_data;
                s0 = out_strb;
                for (int k = 0; k < 5; k++) begin
                    tests++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL bp_stall%0d got in_ready=%b out_valid=%b want in_ready=0 out_valid=1",
                                 k, in_ready, out_valid);
                    end
                    tests++;
                    if (out_data !== d0 || out_strb !== s0) begin
                        fails++;
                        $display("FAIL bp_hold%0d got data=%h strb=%b want data=%h strb=%b",
                                 k, out_data, out_strb, d0, s0);
                    end
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_outs(5);
        tests++; if (q_dat.size() != 5) begin fails++; $display("FAIL bp_count got %0d want 5", q_dat.size()); end
        for (int i = 0; i < 5 && i < q_dat.size(); i++) begin
            tests++;
            if ({q_last[i], q_strb[i], q_dat[i] & bmask(es[i])} !== {el[i], es[i], ed[i] & bmask(es[i])}) begin
                fails++;
                $display("FAIL bp_word%0d got last=%b strb=%b data=%h want last=%b strb=%b data=%h",
                         i, q_last[i], q_strb[i], q_dat[i], el[i], es[i], ed[i]);
            end
        end
    endtask

    task automatic test_zero();
        clear_q();
        send_cmd(2'd1);
        send_word(32'hDEADBEEF, 4'b0000, 1'b1);
        wait_outs(1);
        tests++; if (q_dat.size() != 1) begin fails++; $display("FAIL zero_count got %0d want 1", q_dat.size()); end
        if (q_dat.size() > 0) begin
            tests++;
            if ({q_last[0], q_strb[0]} !== {1'b1, 4'h0}) begin
                fails++;
                $display("FAIL zero_word got last=%b strb=%b want last=1 strb=0000", q_last[0], q_strb[0]);
            end
        end
        tests++; if (done_q.size() != 1) begin fails++; $display("FAIL zero_cmd_done got %0d pulses want 1", done_q.size()); end
    endtask

    task automatic test_cmd_hold();
        logic [31:0] ed [2];
        logic [3:0]  es [2];
        logic        el [2];
        ed = '{32'h22110000, 32'h00000033};
        es = '{4'b1100, 4'b0001};
        el = '{1'b0, 1'b1};
        clear_q();
        send_cmd(2'd2);
        cmd_valid = 1'b1;
        cmd_offset = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL hold_cmd_ready%0d got %b want 0", k, cmd_ready); end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        send_word(32'h44332211, 4'b0111, 1'b1);
        wait_outs(2);
        tests++; if (q_dat.size() != 2) begin fails++; $display("FAIL hold_count got %0d want 2", q_dat.size()); end
        for (int i = 0; i < 2 && i < q_dat.size(); i++) begin
            tests++;
            if ({q_last[i], q_strb[i], q_dat[i] & bmask(es[i])} !== {el[i], es[i], ed[i] & bmask(es[i])}) begin
                fails++;
                $display("FAIL hold_word%0d got last=%b strb=%b data=%h want last=%b strb=%b data=%h",
                         i, q_last[i], q_strb[i], q_dat[i], el[i], es[i], ed[i]);
            end
        end
    endtask

    task automatic test_error_reset();
        clear_q();
        send_cmd(2'd0);
        tests++; if (strb_error !== 1'b0) begin fails++; $display("FAIL err_before got %b want 0", strb_error); end
        send_word(32'hDDCCBBAA, 4'b0101, 1'b0);
        @(negedge clk);
        tests++; if (strb_error !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", strb_error); end
        repeat (3) @(negedge clk);
        tests++; if (strb_error !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", strb_error); end
        @(posedge clk); #1;
        send_word(32'h33221100, 4'hF, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL err_pending got out_valid=%b want 1", out_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        tests++; if (cmd_ready !== 1'b1)  begin fails++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        tests++; if (strb_error !== 1'b0) begin fails++; $display("FAIL rst_strb_error got %b want 0", strb_error); end
        tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_aligned("aligned");
        test_unaligned_src();
        test_offset3();
        test_flush();
        test_backpressure();
        test_zero();
        test_cmd_hold();
        test_error_reset();
        test_aligned("post_rst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
